// File: rtl/register_file_pkg.sv
// Shared constants for the 64-bit RISC-V integer datapath.
// Decode, ALU, writeback and the register file all reuse these values.
package register_file_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

    localparam logic [ADDR_WIDTH-1:0] ZERO_REG = 5'd0;

endpackage : register_file_pkg

// File: rtl/register_file_if.sv
// Decode-side bundle for the register file: two read indices, one write port, two read results.
// The decoder drives through the master modport and the register file answers through the slave modport.
interface register_file_if #(
    parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
);

    logic                  RegWrite;
    logic [ADDR_WIDTH-1:0] rs1;
    logic [ADDR_WIDTH-1:0] rs2;
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] writeData;
    logic [DATA_WIDTH-1:0] readData1;
    logic [DATA_WIDTH-1:0] readData2;

    modport master (
        output RegWrite,
        output rs1,
        output rs2,
        output rd,
        output writeData,
        input  readData1,
        input  readData2
    );

    modport slave (
        input  RegWrite,
        input  rs1,
        input  rs2,
        input  rd,
        input  writeData,
        output readData1,
        output readData2
    );

endinterface : register_file_if

// File: rtl/register_file_read_port.sv
// One combinational read mux of the register file.
// Index 0 is forced to zero, so x0 reads 0 even before the first reset.
module register_file_read_port #(
    parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
) (
    input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] entries,
    input  logic [ADDR_WIDTH-1:0]                    addr,
    output logic [DATA_WIDTH-1:0]                    data
);

    import register_file_pkg::*;

    always_comb begin
        data = '0;
        if (addr != ADDR_WIDTH'(ZERO_REG)) begin
            data = entries[addr];
        end
    end

endmodule : register_file_read_port

// File: rtl/register_file.sv
// Integer register file x0-x31: two combinational read ports and one clocked write port.
// There is no write-to-read bypass, so a read of a register being written returns the old value until the edge.
module register_file #(
    parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = register_file_pkg::ADDR_WIDTH
) (
    input  logic           clk,
    input  logic           reset,
    register_file_if.slave bus
);

    import register_file_pkg::*;

    localparam int NUM_ENTRIES = 2 ** ADDR_WIDTH;

    logic [NUM_ENTRIES-1:0][DATA_WIDTH-1:0] regs;
    logic                                   write_enable;

    assign write_enable = bus.RegWrite && (bus.rd != ADDR_WIDTH'(ZERO_REG));

    // Reset outranks a simultaneous write; x0 is never written, so its slot stays cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs <= '0;
        end else if (write_enable) begin
            regs[bus.rd] <= bus.writeData;
        end
    end

    register_file_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) read_port1 (
        .entries (regs),
        .addr    (bus.rs1),
        .data    (bus.readData1)
    );

    register_file_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) read_port2 (
        .entries (regs),
        .addr    (bus.rs2),
        .data    (bus.readData2)
    );

endmodule : register_file

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed steps followed by random traffic.
// Every step is checked against an array model, both before and after the clock edge.
module tb_register_file;

    import register_file_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    register_file_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    register_file dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DATA_WIDTH-1:0] model       [NUM_REGS];
    bit                    model_known [NUM_REGS];
    int                    compared   = 0;
    int                    mismatched = 0;

    task automatic check(input string tag, input logic [DATA_WIDTH-1:0] observed,
                         input logic [DATA_WIDTH-1:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // x0 always reads zero; every other register is only checked once its contents are defined
    task automatic check_port(input string tag, input logic [ADDR_WIDTH-1:0] idx,
                              input logic [DATA_WIDTH-1:0] observed);
        if (idx == 0) begin
            check(tag, observed, '0);
        end else if (model_known[idx]) begin
            check(tag, observed, model[idx]);
        end
    endtask

    task automatic check_reads(input string tag);
        check_port({tag, "/rd1"}, bus.rs1, bus.readData1);
        check_port({tag, "/rd2"}, bus.rs2, bus.readData2);
    endtask

    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                model[i]       = '0;
                model_known[i] = 1'b1;
            end
        end else if (bus.RegWrite && bus.rd != 0) begin
            model[bus.rd]       = bus.writeData;
            model_known[bus.rd] = 1'b1;
        end
    endtask

    // Apply one cycle of inputs, check reads before the edge, clock, check reads after it
    task automatic step(input string tag, input logic rst, input logic we,
                        input logic [ADDR_WIDTH-1:0] wr_addr, input logic [DATA_WIDTH-1:0] wd,
                        input logic [ADDR_WIDTH-1:0] a1, input logic [ADDR_WIDTH-1:0] a2);
        reset         = rst;
        bus.RegWrite  = we;
        bus.rd        = wr_addr;
        bus.writeData = wd;
        bus.rs1       = a1;
        bus.rs2       = a2;
        #1;
        check_reads({tag, " pre"});
        @(posedge clk);
        model_edge();
        #1;
        check_reads({tag, " post"});
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) begin
            model[i]       = '0;
            model_known[i] = (i == 0);
        end

        reset         = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.rd        = '0;
        bus.writeData = '0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        #2;
        check("x0 before reset", bus.readData1, '0);

        step("reset", 1'b1, 1'b0, 5'd0, '0, 5'd1, 5'd2);
        for (int i = 0; i < NUM_REGS; i++) begin
            step("reset sweep", 1'b0, 1'b0, 5'd0, '0, 5'(i), 5'(NUM_REGS - 1 - i));
        end

        step("write x5", 1'b0, 1'b1, 5'd5, 64'd10, 5'd5, 5'd0);
        step("read x5", 1'b0, 1'b0, 5'd0, '0, 5'd5, 5'd5);
        check("x5 value", bus.readData1, 64'd10);

        step("write x3", 1'b0, 1'b1, 5'd3, 64'd25, 5'd1, 5'd2);
        step("dual read", 1'b0, 1'b0, 5'd0, '0, 5'd3, 5'd5);
        check("dual x3", bus.readData1, 64'd25);
        check("dual x5", bus.readData2, 64'd10);

        step("write x0", 1'b0, 1'b1, 5'd0, 64'd99, 5'd0, 5'd3);
        check("x0 after write", bus.readData1, '0);
        step("x0 side effects", 1'b0, 1'b0, 5'd0, '0, 5'd3, 5'd5);
        check("x3 kept", bus.readData1, 64'd25);
        check("x5 kept", bus.readData2, 64'd10);

        step("gated x7", 1'b0, 1'b0, 5'd7, 64'hDEAD, 5'd7, 5'd7);
        check("x7 gated", bus.readData1, '0);

        reset         = 1'b0;
        bus.RegWrite  = 1'b1;
        bus.rd        = 5'd7;
        bus.writeData = 64'hBEEF;
        bus.rs1       = 5'd7;
        bus.rs2       = 5'd7;
        #1;
        check("x7 pending", bus.readData1, '0);
        @(posedge clk);
        model_edge();
        #1;
        check("x7 written", bus.readData1, 64'hBEEF);
        check("x7 same port", bus.readData2, 64'hBEEF);

        step("reset priority", 1'b1, 1'b1, 5'd9, 64'd55, 5'd9, 5'd3);
        check("x9 lost", bus.readData1, '0);
        step("after reset", 1'b0, 1'b0, 5'd0, '0, 5'd3, 5'd5);
        check("x3 cleared", bus.readData1, '0);
        check("x5 cleared", bus.readData2, '0);

        step("release write", 1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd30);
        check("x31 all ones", bus.readData1, 64'hFFFF_FFFF_FFFF_FFFF);

        for (int n = 0; n < 400; n++) begin
            logic                  rst;
            logic                  we;
            logic [ADDR_WIDTH-1:0] wa;
            logic [ADDR_WIDTH-1:0] ra1;
            logic [ADDR_WIDTH-1:0] ra2;
            logic [DATA_WIDTH-1:0] wd;
            rst = ($urandom_range(0, 39) == 0);
            we  = $urandom_range(0, 3) != 0;
            wa  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, NUM_REGS - 1));
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, NUM_REGS - 1));
            ra2 = ($urandom_range(0, 7) == 0) ? ra1 : 5'($urandom_range(0, NUM_REGS - 1));
            wd  = {$urandom, $urandom};
            step("random", rst, we, wa, wd, ra1, ra2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_register_file
